// File: rtl/wiredpanda_io_pkg.sv
// Shared defaults and sizing helpers for the wiRedPanda input front-end.
package wiredpanda_io_pkg;

   localparam int DEFAULT_SYNC_STAGES     = 2;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

   // Counter must hold 0..n, so one extra code beyond the terminal value.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/wiredpanda_debounce_channel.sv
// One input channel: synchronizer chain, stability counter, clean level and edge pulses.
module wiredpanda_debounce_channel
   import wiredpanda_io_pkg::*;
#(
   parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   output logic clean_o,
   output logic rise_o,
   output logic fall_o,
   output logic flip_o
);

   localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   clean_q, clean_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;

   assign synced = sync_q[SYNC_STAGES-1];

   always_comb begin
      cnt_d   = cnt_q;
      clean_d = clean_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (synced == clean_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         clean_d = ~clean_q;
         cnt_d   = '0;
         rise_d  = synced;
         fall_d  = ~synced;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         clean_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
         cnt_q   <= cnt_d;
         clean_q <= clean_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign clean_o = clean_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;
   // Next-cycle pulse, so the top can register any_change alongside the pulses.
   assign flip_o  = rise_d | fall_d;

endmodule

// File: rtl/wiredpanda_input_conditioner.sv
// Board-input conditioner: per-channel sync + debounce, plus a registered any-change flag.
module wiredpanda_input_conditioner
   import wiredpanda_io_pkg::*;
#(
   parameter int N_INPUTS        = 4,
   parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_INPUTS-1:0] raw_in,
   output logic [N_INPUTS-1:0] clean_out,
   output logic [N_INPUTS-1:0] rise_pulse,
   output logic [N_INPUTS-1:0] fall_pulse,
   output logic                any_change
);

   if (N_INPUTS < 1) begin : g_bad_n_inputs
      $error("N_INPUTS must be >= 1");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync_stages
      $error("SYNC_STAGES must be >= 2");
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
      $error("DEBOUNCE_CYCLES must be >= 1");
   end

   logic [N_INPUTS-1:0] flip;
   logic                any_change_q;

   for (genvar i = 0; i < N_INPUTS; i++) begin : g_ch
      wiredpanda_debounce_channel #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .raw_i   (raw_in[i]),
         .clean_o (clean_out[i]),
         .rise_o  (rise_pulse[i]),
         .fall_o  (fall_pulse[i]),
         .flip_o  (flip[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         any_change_q <= 1'b0;
      end else begin
         any_change_q <= |flip;
      end
   end

   assign any_change = any_change_q;

endmodule

// File: doc/wiredpanda_input_conditioner.md
# wiredpanda_input_conditioner

Input front-end that sits directly upstream of a wiRedPanda-generated circuit module. It takes asynchronous raw board inputs (push-buttons, switches), synchronizes them into the system clock domain, and debounces each one with a per-channel stability counter. It drives clean levels into the generated module's input ports, plus one-cycle rising and falling edge pulses for clocked or toggle-style elements.

## Interface
Parameters:
- `N_INPUTS`, default 4: number of independent input channels; must be ≥1.
- `SYNC_STAGES`, default 2: synchronizer flop depth; must be ≥2.
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required to accept a change; must be ≥1.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `raw_in`  in  N_INPUTS  unsynchronized board inputs; may change at any time.
- `clean_out`  out  N_INPUTS  debounced levels fed to the generated module's inputs.
- `rise_pulse`  out  N_INPUTS  one-cycle high when the matching `clean_out` bit goes 0→1.
- `fall_pulse`  out  N_INPUTS  one-cycle high when the matching `clean_out` bit goes 1→0.
- `any_change`  out  1  OR of all `rise_pulse` and `fall_pulse` bits, registered in the same cycle as the pulses.

## Operation
- Per channel, `raw_in[i]` passes through a `SYNC_STAGES`-deep flop chain. The last stage is `synced[i]`.
- Each channel has a counter of width `$clog2(DEBOUNCE_CYCLES+1)`, a registered `clean` bit, and registered pulse bits.
- Every edge, the following rules apply:
  - If `synced == clean`: the counter is cleared to 0.
  - Else, if counter == `DEBOUNCE_CYCLES-1`: `clean` is inverted, the counter is cleared, and the corresponding pulse is set for exactly one cycle.
  - Else: the counter increments by 1. It never exceeds `DEBOUNCE_CYCLES-1`, so wrap-around is impossible.
- The pulse registers default to 0 every cycle unless set by a flip. `rise_pulse` and `fall_pulse` for the same channel are never high together.
- Channels are fully independent. Simultaneous flips on several channels assert all of their pulses in the same cycle, and `any_change` is asserted once.
- `DEBOUNCE_CYCLES == 1`: a single mismatched `synced` cycle flips `clean`. The counter stays 0.
- Reset (`rst_n` low, any time, including mid-count):
  - Immediately clears all synchronizer flops, counters, `clean_out`, `rise_pulse`, `fall_pulse`, and `any_change` to 0.
  - A raw input held high through reset is then accepted normally after the full latency and produces a `rise_pulse`.
- No X propagation: every flop is reset.

## Timing
- Latency: for a raw change that settles before edge 1 and stays stable, `synced` changes at edge `SYNC_STAGES`, and `clean_out` plus the pulse change at edge `SYNC_STAGES + DEBOUNCE_CYCLES`.
- Rejection: a change that is stable for `DEBOUNCE_CYCLES-1` or fewer cycles at `synced` never reaches `clean_out`.
- Acceptance: a change that is stable for exactly `DEBOUNCE_CYCLES` cycles is always accepted.
- A bounce back to the `clean` level during counting restarts the count from 0 on that edge.
- Pulses are one cycle wide and coincide with the `clean_out` transition cycle.
- All outputs are registered; there are no combinational paths from `raw_in` to any output.
- Deassertion of `rst_n` is expected synchronous to `clk` at board level. The block itself makes no release-synchronization guarantees.

## Structure
- Shared package `wiredpanda_io_pkg`:
  - `DEFAULT_SYNC_STAGES` = 2.
  - `DEFAULT_DEBOUNCE_CYCLES` = 16.
  - Function `cnt_width(n)` returning `$clog2(n+1)`.
- Sub-module `wiredpanda_debounce_channel`: one synchronizer, counter, clean bit, and pulse pair.
  - The top instantiates it `N_INPUTS` times in a generate loop.
  - The top also registers the `any_change` reduction.
- Parameter legality is checked with elaboration-time assertions (`SYNC_STAGES ≥ 2`, `DEBOUNCE_CYCLES ≥ 1`, `N_INPUTS ≥ 1`).

## Test plan
Bench parameters: `N_INPUTS=4`, `SYNC_STAGES=2`, `DEBOUNCE_CYCLES=4`.
1. **Reset values:** assert `rst_n` low with `raw_in=4'b1111` → all outputs are 0 during reset. After release, `clean_out` becomes `4'b1111` at edge 6. `rise_pulse=4'b1111` and `any_change=1` for exactly that cycle.
2. **Stable change accepted:** `raw_in[0]` 0→1 held → `clean_out[0]` rises at edge 6 after the change, `rise_pulse[0]` is high for one cycle, and other bits stay 0. Then 1→0 held → `fall_pulse[0]` fires 6 edges later.
3. **Glitch rejected:** `raw_in[1]` high for 3 cycles then low → `clean_out[1]` stays 0 and no pulses occur. High for 4 cycles → accepted.
4. **Bounce restart:** `raw_in[2]` pattern 1,1,0,1,1,1,1 → the count restarts at the 0, and `clean_out[2]` rises 6 edges after the final 0→1 transition.
5. **Simultaneous channels:** `raw_in` 4'b0000→4'b1010 in one cycle → `rise_pulse=4'b1010` in a single cycle with `any_change=1`.
6. **Reset mid-count:** `raw_in[3]` 0→1, then pull `rst_n` low 2 edges before acceptance → immediate all-zero outputs. After release, the full 6-edge latency restarts before `rise_pulse[3]`.
